decode_regfile_sb: RTL and testbench

- Parametrised register file for the decode stage of the pipelined CPU.
- Provides NREAD combinational read ports, one writeback write port, and an internal write-through bypass.
- Adds a per-register pending-write scoreboard that flags read-after-write hazards to the hazard unit. It replaces the fixed 2-read register file plus external hazard compare.

---
 rtl/decode_regfile_sb_if.sv | 32 +++
 rtl/decode_regfile_sb.sv | 85 ++++++++
 tb/tb_decode_regfile_sb.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_regfile_sb_if.sv
// Decode register file bus: read ports, writeback port and issue/scoreboard controls.
// The master modport drives selects and writebacks; the slave modport is the register file.
interface decode_regfile_sb_if #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int NREAD  = 2
);
  logic [NREAD*REG_W-1:0]  rsel;
  logic [NREAD*WORD_W-1:0] rdat;
  logic [NREAD-1:0]        rbusy;
  logic                    hazard;
  logic                    wen;
  logic [REG_W-1:0]        wsel;
  logic [WORD_W-1:0]       wdat;
  logic                    issue_en;
  logic [REG_W-1:0]        issue_dst;
  logic                    stall;
  logic                    flush;
  logic                    issue_full;

  modport master (
    output rsel, wen, wsel, wdat,
    output issue_en, issue_dst, stall, flush,
    input  rdat, rbusy, hazard, issue_full
  );

  modport slave (
    input  rsel, wen, wsel, wdat,
    input  issue_en, issue_dst, stall, flush,
    output rdat, rbusy, hazard, issue_full
  );
endinterface

// File: rtl/decode_regfile_sb.sv
// Decode register file with per-register pending-write scoreboard.
// Define DECODE_REGFILE_BYPASS_EN for same-cycle writeback-to-read bypass.
module decode_regfile_sb #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int NREAD  = 2,
  parameter int CNT_W  = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  decode_regfile_sb_if.slave bus
);
  localparam int NREGS = 2**REG_W;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [WORD_W-1:0] regs    [NREGS];
  logic [CNT_W-1:0]  cnt     [NREGS];
  logic [CNT_W-1:0]  cnt_nxt [NREGS];
  logic              inc_ok;
  logic [REG_W-1:0]  s;
  logic [WORD_W-1:0] d;
  logic              sat;

  assign bus.issue_full = bus.issue_en
                        && (bus.issue_dst != '0)
                        && (cnt[bus.issue_dst] == CMAX);

  assign inc_ok = bus.issue_en && !bus.stall
               && !bus.flush && !bus.issue_full
               && (bus.issue_dst != '0);

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      logic inc, dec;
      inc = inc_ok && (bus.issue_dst == REG_W'(r));
      dec = bus.wen && (bus.wsel == REG_W'(r))
         && (cnt[r] != '0);
      cnt_nxt[r] = cnt[r];
      if (bus.flush)
        cnt_nxt[r] = '0;
      else if (inc && !dec)
        cnt_nxt[r] = cnt[r] + 1'b1;
      else if (dec && !inc)
        cnt_nxt[r] = cnt[r] - 1'b1;
    end
  end

  // regs[0] is only ever cleared, so storage reads of r0 return 0
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (bus.wen && bus.wsel != '0)
        regs[bus.wsel] <= bus.wdat;
      for (int r = 0; r < NREGS; r++)
        cnt[r] <= cnt_nxt[r];
    end
  end

  always_comb begin
    bus.rdat  = '0;
    bus.rbusy = '0;
    s   = '0;
    d   = '0;
    sat = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      s   = bus.rsel[i*REG_W +: REG_W];
      d   = regs[s];
      sat = 1'b0;
`ifdef DECODE_REGFILE_BYPASS_EN
      if (bus.wen && bus.wsel == s && s != '0) begin
        d   = bus.wdat;
        sat = (cnt[s] == CNT_W'(1));
      end
`endif
      bus.rdat[i*WORD_W +: WORD_W] = d;
      bus.rbusy[i] = (s != '0) && (cnt[s] != '0) && !sat;
    end
  end

  assign bus.hazard = |bus.rbusy;
endmodule

// File: tb/tb_decode_regfile_sb.sv
// Directed bench for decode_regfile_sb (default parameters).
// Expectations follow DECODE_REGFILE_BYPASS_EN when it is defined.
module tb_decode_regfile_sb;
  logic CLK;
  logic nRST;
  int   checks;
  int   passed;

  decode_regfile_sb_if bus ();

  decode_regfile_sb dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.rsel      = '0;
    bus.wen       = 1'b0;
    bus.wsel      = '0;
    bus.wdat      = '0;
    bus.issue_en  = 1'b0;
    bus.issue_dst = '0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic issue(input logic [4:0] dst);
    idle();
    bus.issue_en  = 1'b1;
    bus.issue_dst = dst;
    step();
  endtask

  task automatic test_reset();
    idle();
    nRST = 1'b0;
    #2;
    checks++;
    if (bus.rdat !== 64'h0)
      $display("FAIL reset_rdat got %h want 0", bus.rdat);
    else passed++;
    checks++;
    if (bus.hazard !== 1'b0)
      $display("FAIL reset_hazard got %b want 0", bus.hazard);
    else passed++;
    checks++;
    if (bus.issue_full !== 1'b0)
      $display("FAIL reset_full got %b want 0", bus.issue_full);
    else passed++;
    nRST = 1'b1;
    step();
    idle();
    bus.wen  = 1'b1;
    bus.wsel = 5'd5;
    bus.wdat = 32'hDEAD;
    step();
    issue(5'd5);
    issue(5'd5);
    idle();
    bus.rsel[4:0] = 5'd5;
    #1;
    checks++;
    if (bus.rdat[31:0] !== 32'hDEAD)
      $display("FAIL pre_reset_rdat got %h want dead", bus.rdat[31:0]);
    else passed++;
    checks++;
    if (bus.rbusy !== 2'b01)
      $display("FAIL pre_reset_rbusy got %b want 01", bus.rbusy);
    else passed++;
    nRST = 1'b0;
    #1;
    checks++;
    if (bus.rdat[31:0] !== 32'h0)
      $display("FAIL async_reset_rdat got %h want 0", bus.rdat[31:0]);
    else passed++;
    checks++;
    if (bus.hazard !== 1'b0)
      $display("FAIL async_reset_hazard got %b want 0", bus.hazard);
    else passed++;
    nRST = 1'b1;
    step();
    checks++;
    if (bus.rbusy !== 2'b00)
      $display("FAIL post_reset_rbusy got %b want 00", bus.rbusy);
    else passed++;
  endtask

  task automatic test_reg0();
    idle();
    bus.wen       = 1'b1;
    bus.wsel      = 5'd0;
    bus.wdat      = 32'hFFFF_FFFF;
    bus.issue_en  = 1'b1;
    bus.issue_dst = 5'd0;
    #1;
    checks++;
    if (bus.issue_full !== 1'b0)
      $display("FAIL reg0_full got %b want 0", bus.issue_full);
    else passed++;
    step();
    idle();
    #1;
    checks++;
    if (bus.rdat !== 64'h0)
      $display("FAIL reg0_rdat got %h want 0", bus.rdat);
    else passed++;
    checks++;
    if (bus.rbusy !== 2'b00)
      $display("FAIL reg0_rbusy got %b want 00", bus.rbusy);
    else passed++;
  endtask

  task automatic test_raw();
    issue(5'd3);
    idle();
    bus.rsel[4:0] = 5'd3;
    #1;
    checks++;
    if (bus.rbusy !== 2'b01)
      $display("FAIL raw_rbusy got %b want 01", bus.rbusy);
    else passed++;
    checks++;
    if (bus.hazard !== 1'b1)
      $display("FAIL raw_hazard got %b want 1", bus.hazard);
    else passed++;
    step();
    bus.wen  = 1'b1;
    bus.wsel = 5'd3;
    bus.wdat = 32'h1234;
    #1;
`ifdef DECODE_REGFILE_BYPASS_EN
    checks++;
    if (bus.rdat[31:0] !== 32'h1234)
      $display("FAIL raw_bypass_rdat got %h want 1234", bus.rdat[31:0]);
    else passed++;
    checks++;
    if (bus.hazard !== 1'b0)
      $display("FAIL raw_wb_hazard got %b want 0", bus.hazard);
    else passed++;
`else
    checks++;
    if (bus.rdat[31:0] !== 32'h0)
      $display("FAIL raw_wb_rdat got %h want 0", bus.rdat[31:0]);
    else passed++;
    checks++;
    if (bus.hazard !== 1'b1)
      $display("FAIL raw_wb_hazard got %b want 1", bus.hazard);
    else passed++;
`endif
    step();
    idle();
    bus.rsel[4:0] = 5'd3;
    #1;
    checks++;
    if (bus.hazard !== 1'b0)
      $display("FAIL raw_after_hazard got %b want 0", bus.hazard);
    else passed++;
    checks++;
    if (bus.rdat[31:0] !== 32'h1234)
      $display("FAIL raw_after_rdat got %h want 1234", bus.rdat[31:0]);
    else passed++;
  endtask

  task automatic test_saturation();
    issue(5'd7);
    issue(5'd7);
    issue(5'd7);
    idle();
    bus.issue_en  = 1'b1;
    bus.issue_dst = 5'd7;
    #1;
    checks++;
    if (bus.issue_full !== 1'b1)
      $display("FAIL sat_full got %b want 1", bus.issue_full);
    else passed++;
    step();
    #1;
    checks++;
    if (bus.issue_full !== 1'b1)
      $display("FAIL sat_hold got %b want 1", bus.issue_full);
    else passed++;
    bus.wen  = 1'b1;
    bus.wsel = 5'd7;
    bus.wdat = 32'h77;
    step();
    idle();
    bus.issue_en  = 1'b1;
    bus.issue_dst = 5'd7;
    #1;
    checks++;
    if (bus.issue_full !== 1'b0)
      $display("FAIL sat_dec_full got %b want 0", bus.issue_full);
    else passed++;
    idle();
    bus.rsel[4:0] = 5'd7;
    bus.wen  = 1'b1;
    bus.wsel = 5'd7;
    step();
    bus.wen = 1'b0;
    #1;
    checks++;
    if (bus.rbusy !== 2'b01)
      $display("FAIL sat_cnt1 got %b want 01", bus.rbusy);
    else passed++;
    bus.wen = 1'b1;
    step();
    bus.wen = 1'b0;
    #1;
    checks++;
    if (bus.rbusy !== 2'b00)
      $display("FAIL sat_cnt0 got %b want 00", bus.rbusy);
    else passed++;
  endtask

  task automatic test_simultaneous();
    issue(5'd4);
    idle();
    bus.issue_en  = 1'b1;
    bus.issue_dst = 5'd4;
    bus.wen  = 1'b1;
    bus.wsel = 5'd4;
    bus.wdat = 32'hAA;
    step();
    idle();
    bus.rsel[4:0] = 5'd4;
    #1;
    checks++;
    if (bus.rbusy !== 2'b01)
      $display("FAIL simul_rbusy got %b want 01", bus.rbusy);
    else passed++;
    checks++;
    if (bus.rdat[31:0] !== 32'hAA)
      $display("FAIL simul_rdat got %h want aa", bus.rdat[31:0]);
    else passed++;
    bus.wen  = 1'b1;
    bus.wsel = 5'd4;
    bus.wdat = 32'hAB;
    step();
    idle();
  endtask

  task automatic test_stall_flush();
    idle();
    bus.issue_en  = 1'b1;
    bus.issue_dst = 5'd9;
    bus.stall     = 1'b1;
    step();
    idle();
    bus.rsel[4:0] = 5'd9;
    #1;
    checks++;
    if (bus.rbusy !== 2'b00)
      $display("FAIL stall_rbusy got %b want 00", bus.rbusy);
    else passed++;
    issue(5'd9);
    issue(5'd9);
    issue(5'd3);
    idle();
    bus.rsel = {5'd3, 5'd9};
    #1;
    checks++;
    if (bus.rbusy !== 2'b11)
      $display("FAIL preflush_rbusy got %b want 11", bus.rbusy);
    else passed++;
    bus.flush     = 1'b1;
    bus.issue_en  = 1'b1;
    bus.issue_dst = 5'd9;
    bus.wen       = 1'b1;
    bus.wsel      = 5'd9;
    bus.wdat      = 32'h55;
    step();
    idle();
    bus.rsel = {5'd3, 5'd9};
    #1;
    checks++;
    if (bus.rbusy !== 2'b00)
      $display("FAIL flush_rbusy got %b want 00", bus.rbusy);
    else passed++;
    checks++;
    if (bus.rdat[31:0] !== 32'h55)
      $display("FAIL flush_rdat got %h want 55", bus.rdat[31:0]);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    nRST   = 1'b0;
    test_reset();
    test_reg0();
    test_raw();
    test_saturation();
    test_simultaneous();
    test_stall_flush();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
